// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered immediate-decode stage between fetch and execute. It decodes
//   the immediate and format of each RV32I/RV64I instruction, flags illegal
//   opcodes, and passes instructions downstream through a valid/ready
//   handshake. A 2-entry buffer (main + skid) lets the stage absorb one
//   extra instruction under back-pressure. A saturating counter tracks the
//   number of accepted illegal instructions.
//
// Parameters
//   XLEN   datapath width (32 or 64)
//   CNT_W  width of the illegal-instruction counter
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush of both entries
//   in_valid/in_ready     upstream handshake (in_ready = skid entry empty)
//   in_instr, in_pc       instruction word and its PC
//   out_valid/out_ready   downstream handshake
//   out_imm, out_fmt      decoded immediate and format code
//   out_pc, out_illegal   carried PC and illegal-opcode flag
//   illegal_cnt           saturating count of accepted illegal instructions
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  // ---------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [5:0]      shamt;
  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Size casts of signed operands sign-extend to XLEN for either width.
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));
  // RV32 shift amounts are 5 bits; bit 25 only participates on RV64.
  assign shamt  = {(XLEN == 64) ? in_instr[25] : 1'b0, in_instr[24:20]};
  assign imm_sh = XLEN'(shamt);

  always_comb begin
    dec_fmt = FMT_ILLEGAL;
    dec_imm = '0;
    unique case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FMT_SHAMT;
          dec_imm = imm_sh;
        end else begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = imm_s;
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = imm_b;
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = imm_u;
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = imm_j;
      end
      7'b0110011: dec_fmt = FMT_R;
      7'b0111011: dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILLEGAL;
      default:    dec_fmt = FMT_ILLEGAL;
    endcase
  end

  assign dec_illegal = (dec_fmt == FMT_ILLEGAL);

  // ---------------------------------------------------------------
  // Main + skid entries
  // ---------------------------------------------------------------
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic [XLEN-1:0] skid_pc;
  logic            skid_illegal;
  logic            accept;

  // in_ready is the inverse of a flop, so it is registered by construction.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_fmt      <= '0;
      out_pc       <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= '0;
      skid_pc      <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Skid occupied implies main occupied and no new input accepted.
      if (out_ready) begin
        out_imm     <= skid_imm;
        out_fmt     <= skid_fmt;
        out_pc      <= skid_pc;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end
    end else if (!out_valid || out_ready) begin
      // Main is free or draining this cycle: new input lands directly in main.
      out_valid <= accept;
      if (accept) begin
        out_imm     <= dec_imm;
        out_fmt     <= dec_fmt;
        out_pc      <= in_pc;
        out_illegal <= dec_illegal;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_pc      <= in_pc;
      skid_illegal <= dec_illegal;
    end
  end

  // ---------------------------------------------------------------
  // Saturating illegal-instruction counter (survives flush)
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && dec_illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Testbench for imm_decode_stage: drives identical stimulus into an XLEN=32
// and an XLEN=64 instance and compares both against a queue-based
// reference model of the stage.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_pc32;
  logic [2:0]  out_fmt32;
  logic [7:0]  cnt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_pc64;
  logic [2:0]  out_fmt64;
  logic [7:0]  cnt64;

  int unsigned checks;
  int unsigned failures;

  imm_decode_stage #(.XLEN(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_pc(out_pc32),
    .out_illegal(out_illegal32), .illegal_cnt(cnt32)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_pc(out_pc64),
    .out_illegal(out_illegal64), .illegal_cnt(cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t q[$];
  int     m_cnt32;
  int     m_cnt64;

  function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                     output logic [63:0] imm, output logic [2:0] fmt);
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    op  = ins[6:0];
    f3  = ins[14:12];
    v   = 0;
    fmt = 3'd7;
    case (op)
      7'b0010011:
        if (f3 == 3'd1 || f3 == 3'd5) begin
          fmt = 3'd6;
          v = rv64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
        end else begin
          fmt = 3'd1;
          v = $signed(ins[31:20]);
        end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt = 3'd1; v = $signed(ins[31:20]);
      end
      7'b0100011: begin
        fmt = 3'd2; v = $signed({ins[31:25], ins[11:7]});
      end
      7'b1100011: begin
        fmt = 3'd3; v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4; v = $signed({ins[31:12], 12'b0});
      end
      7'b1101111: begin
        fmt = 3'd5; v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      end
      7'b0110011: fmt = 3'd0;
      7'b0111011: fmt = rv64 ? 3'd0 : 3'd7;
      default:    fmt = 3'd7;
    endcase
    imm = v;
  endfunction

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    int sz;
    entry_t e;
    logic [63:0] imm;
    logic [2:0]  fmt;
    if (!rst_n) begin
      q.delete();
      m_cnt32 = 0;
      m_cnt64 = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      sz = q.size();
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < 2) begin
        e.instr = in_instr;
        e.pc    = in_pc;
        q.push_back(e);
        ref_decode(in_instr, 1'b0, imm, fmt);
        if (fmt == 3'd7 && m_cnt32 < 255) m_cnt32++;
        ref_decode(in_instr, 1'b1, imm, fmt);
        if (fmt == 3'd7 && m_cnt64 < 255) m_cnt64++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] imm;
    logic [2:0]  fmt;
    chk("valid32", 64'(out_valid32), 64'(q.size() > 0));
    chk("valid64", 64'(out_valid64), 64'(q.size() > 0));
    chk("ready32", 64'(in_ready32), 64'(q.size() < 2));
    chk("ready64", 64'(in_ready64), 64'(q.size() < 2));
    chk("cnt32", 64'(cnt32), 64'(m_cnt32));
    chk("cnt64", 64'(cnt64), 64'(m_cnt64));
    if (q.size() > 0) begin
      ref_decode(q[0].instr, 1'b0, imm, fmt);
      chk("imm32", 64'(out_imm32), 64'(imm[31:0]));
      chk("fmt32", 64'(out_fmt32), 64'(fmt));
      chk("pc32", 64'(out_pc32), 64'(q[0].pc[31:0]));
      chk("ill32", 64'(out_illegal32), 64'(fmt == 3'd7));
      ref_decode(q[0].instr, 1'b1, imm, fmt);
      chk("imm64", out_imm64, imm);
      chk("fmt64", 64'(out_fmt64), 64'(fmt));
      chk("pc64", out_pc64, q[0].pc);
      chk("ill64", 64'(out_illegal64), 64'(fmt == 3'd7));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic offer(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = {$urandom, $urandom & 32'hFFFF_FFFC};
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_valid64"}, 64'(out_valid64), 64'd0);
    chk({tag, "_ready32"}, 64'(in_ready32), 64'd1);
    chk({tag, "_ready64"}, 64'(in_ready64), 64'd1);
    chk({tag, "_cnt32"}, 64'(cnt32), 64'd0);
    chk({tag, "_imm32"}, 64'(out_imm32), 64'd0);
    chk({tag, "_imm64"}, out_imm64, 64'd0);
    chk({tag, "_fmt32"}, 64'(out_fmt32), 64'd0);
    chk({tag, "_pc64"}, out_pc64, 64'd0);
    chk({tag, "_ill32"}, 64'(out_illegal32), 64'd0);
  endtask

  logic [6:0] ops [12];
  int saved_cnt;

  initial begin
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
            7'b0111011, 7'b0001111};
    checks = 0; failures = 0;
    m_cnt32 = 0; m_cnt64 = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b1;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();

    // addi x1,x0,-1 with one-cycle latency
    offer(32'hFFF00093);
    step();
    chk("addi_imm", 64'(out_imm32), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(out_fmt32), 64'd1);
    chk("addi_valid", 64'(out_valid32), 64'd1);

    // streaming S/B/U/J
    offer(32'hFE112E23); step(); chk("sw_imm", 64'(out_imm32), 64'hFFFF_FFFC);
    offer(32'hFE000CE3); step(); chk("beq_imm", 64'(out_imm32), 64'hFFFF_FFF8);
    chk("beq_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFF8);
    offer(32'h123450B7); step(); chk("lui_imm", 64'(out_imm32), 64'h1234_5000);
    offer(32'h001000EF); step(); chk("jal_imm", 64'(out_imm32), 64'h0000_0800);
    offer(32'h02009093); step();
    chk("slli_fmt64", 64'(out_fmt64), 64'd6);
    chk("slli_imm64", out_imm64, 64'd32);
    in_valid = 1'b0; step();

    // back-pressure: three offered, two accepted, drained in order
    out_ready = 1'b0;
    offer(32'hFFF00093); step();
    offer(32'hFE112E23); step();
    chk("bp_ready_full", 64'(in_ready32), 64'd0);
    offer(32'h123450B7); step();
    chk("bp_hold_imm", 64'(out_imm32), 64'hFFFF_FFFF);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("bp_second_imm", 64'(out_imm32), 64'hFFFF_FFFC);
    chk("bp_ready_back", 64'(in_ready32), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid32), 64'd0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      in_instr  = {$urandom_range(0, 32'h01FF_FFFF), 7'b0};
      in_instr[6:0] = ((($urandom % 8) == 0) ? 7'($urandom) : ops[$urandom % 12]);
      in_pc     = {$urandom, $urandom};
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    // 300 illegal instructions saturate the counter
    for (int i = 0; i < 300; i++) begin
      offer(32'h0000_0000);
      step();
      chk("zero_fmt", 64'(out_fmt32), 64'd7);
      chk("zero_ill", 64'(out_illegal64), 64'd1);
    end
    in_valid = 1'b0; step();
    chk("sat_cnt32", 64'(cnt32), 64'd255);
    chk("sat_cnt64", 64'(cnt64), 64'd255);

    // fill both entries, then flush with input offered
    out_ready = 1'b0;
    offer(32'hFFF00093); step();
    offer(32'h0000_0000); step();
    saved_cnt = cnt32;
    offer(32'h0000_0000); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid32), 64'd0);
    chk("flush_ready", 64'(in_ready64), 64'd1);
    chk("flush_cnt", 64'(cnt32), 64'(saved_cnt));

    // asynchronous reset mid-stream
    out_ready = 1'b1;
    offer(32'hFE000CE3); step();
    offer(32'h123450B7); step();
    #3 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    q.delete(); m_cnt32 = 0; m_cnt64 = 0;
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      offer(ops[$urandom % 12] | (32'($urandom) & 32'hFFFF_FF80));
      out_ready = ($urandom % 2) != 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
